// File: rtl/receptor_pkg.sv
// Shared encodings and sizing helper for the multichannel serial receiver.
// Packet-layer states are visible on the debug port, so their values are fixed.
package receptor_pkg;

  typedef enum logic [2:0] {
    ESPERA_SYNC = 3'd0,
    DATOS       = 3'd1,
    CHECKSUM    = 3'd2
  } pkt_state_t;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_START = 2'd1,
    B_DATA  = 2'd2,
    B_STOP  = 2'd3
  } byte_state_t;

  // Width needed to count up to clks_per_bit * bit_periods inclusive.
  function automatic int cnt_width(input int clks_per_bit, input int bit_periods);
    int max_count;
    max_count = clks_per_bit * bit_periods;
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Async-serial byte receiver: 2-flop sync, mid-bit start check, LSB-first sampling, stop check.
// byte_valid/byte_err pulse one cycle after the stop-bit sample; no backpressure, bytes are never held.
module uart_rx_byte
  import receptor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              byte_err,
  output logic              rx_idle
);

  localparam int CW = cnt_width(CLKS_PER_BIT, 1);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);

  byte_state_t       st, st_next;
  logic              sync_a, rx_s;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W:0]   sh_next;
  logic              tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_a <= rx;
      rx_s   <= sync_a;
    end
  end

  // Start bit is checked half a bit in; data and stop are then sampled one full bit apart.
  assign tick = (st == B_START) ? (cnt == HALF_LAST)
              : ((st == B_DATA) || (st == B_STOP)) && (cnt == FULL_LAST);
  assign sh_next = {rx_s, shreg} >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= B_IDLE;
    else     st <= st_next;
  end

  always_comb begin
    st_next = st;
    case (st)
      B_IDLE:  if (!rx_s) st_next = B_START;
      B_START: if (tick) st_next = rx_s ? B_IDLE : B_DATA;
      B_DATA:  if (tick && (bit_idx == LAST_BIT)) st_next = B_STOP;
      B_STOP:  if (tick) st_next = B_IDLE;
      default: st_next = B_IDLE;
    endcase
  end

  always_comb begin
    rx_idle  = (st == B_IDLE);
    byte_out = shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (tick || (st == B_IDLE)) cnt <= '0;
      else                        cnt <= cnt + 1'b1;
      if (st == B_START) bit_idx <= '0;
      if ((st == B_DATA) && tick) begin
        shreg   <= sh_next[DATA_W-1:0];
        bit_idx <= bit_idx + 1'b1;
      end
      if ((st == B_STOP) && tick) begin
        byte_valid <= rx_s;
        byte_err   <= !rx_s;
      end
    end
  end

endmodule

// File: rtl/receptor_serial_multicanal.sv
// Servo-link packet receiver: sync byte, NUM_CANALES data bytes, additive checksum; angulos update atomically.
// frame_valid/frame_error pulse 2 clk after the last stop-bit sample; the serial line cannot be stalled.
module receptor_serial_multicanal
  import receptor_pkg::*;
#(
  parameter int                CLKS_PER_BIT = 10,
  parameter int                DATA_W       = 8,
  parameter int                NUM_CANALES  = 4,
  parameter logic [DATA_W-1:0] SYNC_BYTE    = DATA_W'(8'hFF),
  parameter int                TIMEOUT_BITS = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          canal_serial,
  output logic [NUM_CANALES*DATA_W-1:0] angulos,
  output logic                          frame_valid,
  output logic                          frame_error,
  output logic                          busy,
  output logic [2:0]                    state
);

  localparam int TO_W  = cnt_width(CLKS_PER_BIT, TIMEOUT_BITS);
  localparam int IDX_W = (NUM_CANALES > 1) ? $clog2(NUM_CANALES) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CANALES - 1);

  pkt_state_t                              st, st_next;
  logic [DATA_W-1:0]                       rx_byte, sum;
  logic                                    byte_valid, byte_err, rx_idle;
  logic [NUM_CANALES-1:0][DATA_W-1:0]      shadow;
  logic [IDX_W-1:0]                        idx;
  logic [TO_W-1:0]                         to_cnt;
  logic                                    timeout, good_frame, bad_frame;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_W      (DATA_W)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (canal_serial),
    .byte_out  (rx_byte),
    .byte_valid(byte_valid),
    .byte_err  (byte_err),
    .rx_idle   (rx_idle)
  );

  assign timeout = (st != ESPERA_SYNC) && rx_idle && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= ESPERA_SYNC;
    else     st <= st_next;
  end

  always_comb begin
    st_next    = st;
    good_frame = 1'b0;
    bad_frame  = 1'b0;
    case (st)
      ESPERA_SYNC: if (byte_valid && (rx_byte == SYNC_BYTE)) st_next = DATOS;
      DATOS: begin
        if (byte_err || timeout) begin
          bad_frame = 1'b1;
          st_next   = ESPERA_SYNC;
        end else if (byte_valid && (idx == IDX_LAST)) begin
          st_next = CHECKSUM;
        end
      end
      CHECKSUM: begin
        if (byte_err || timeout) begin
          bad_frame = 1'b1;
          st_next   = ESPERA_SYNC;
        end else if (byte_valid) begin
          good_frame = (rx_byte == sum);
          bad_frame  = (rx_byte != sum);
          st_next    = ESPERA_SYNC;
        end
      end
      default: st_next = ESPERA_SYNC;
    endcase
  end

  always_comb begin
    busy  = !rx_idle || (st != ESPERA_SYNC);
    state = st;
  end

  // Data bytes land in shadow; angulos only ever change by a whole-packet copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angulos     <= '0;
      shadow      <= '0;
      sum         <= '0;
      idx         <= '0;
      to_cnt      <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= good_frame;
      frame_error <= bad_frame;
      if (good_frame) angulos <= shadow;
      if (st == ESPERA_SYNC) begin
        idx <= '0;
        sum <= '0;
      end else if ((st == DATOS) && byte_valid) begin
        shadow[idx] <= rx_byte;
        sum         <= sum + rx_byte;
        idx         <= idx + 1'b1;
      end
      if ((st == ESPERA_SYNC) || !rx_idle || timeout) to_cnt <= '0;
      else                                             to_cnt <= to_cnt + 1'b1;
    end
  end

endmodule
